simon_control_inl: RTL and testbench

SIMON_CONTROL_INL -- requirements
Module: simon_control_inl

---
 rtl/simon_pkg.sv | 29 ++
 rtl/simon_round.sv | 39 +++
 rtl/simon_control_inl.sv | 137 +++++++++++++
 tb/tb_simon_control_inl.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/simon_pkg.sv
// Shared definitions for the SIMON32/64 inline-key encryptor:
// parameter defaults, key-schedule constants and the controller state type.
package simon_pkg;

    localparam int unsigned N_DEF  = 16;  // word width
    localparam int unsigned M_DEF  = 4;   // key words
    localparam int unsigned T_DEF  = 32;  // rounds
    localparam int unsigned C_DEF  = 5;   // round-counter width

    // z0 sequence; bit position 0 of the sequence is the leftmost bit of the literal
    localparam int unsigned Z0_LEN = 62;
    localparam logic [Z0_LEN-1:0] Z0 =
        62'b11111010001001010110000111001101111101000100101011000011100110;

    // ~3: folds the complement of k0 and the constant 3 into one xor term
    localparam logic [15:0] ROUND_CONST = 16'hFFFC;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Bit idx of z0, counted from the leftmost bit of the sequence
    function automatic logic z0_bit(input logic [5:0] idx);
        return Z0[6'(Z0_LEN - 1) - idx];
    endfunction

endpackage

// File: rtl/simon_round.sv
// Combinational SIMON round plus next-key computation.
// Given the current state words and key window, produces the next x word and
// the key word that enters the top of the key window.
module simon_round
    import simon_pkg::*;
#(
    parameter int unsigned N = N_DEF,
    parameter int unsigned C = C_DEF
) (
    input  logic [N-1:0] x_i,
    input  logic [N-1:0] y_i,
    input  logic [N-1:0] k0_i,       // current round key (oldest key word)
    input  logic [N-1:0] k1_i,       // second-oldest key word
    input  logic [N-1:0] k_last_i,   // newest key word
    input  logic [C-1:0] round_i,    // round index, selects the z0 bit
    output logic [N-1:0] x_next_c_o,
    output logic [N-1:0] key_new_c_o
);

    function automatic logic [N-1:0] rotl(input logic [N-1:0] v, input int unsigned s);
        return (v << s) | (v >> (N - s));
    endfunction

    function automatic logic [N-1:0] rotr(input logic [N-1:0] v, input int unsigned s);
        return (v >> s) | (v << (N - s));
    endfunction

    logic [N-1:0] t;

    // Round function and inline key expansion
    always_comb begin
        x_next_c_o  = y_i ^ (rotl(x_i, 1) & rotl(x_i, 8)) ^ rotl(x_i, 2) ^ k0_i;

        t           = rotr(k_last_i, 3) ^ k1_i;
        key_new_c_o = k0_i ^ N'(ROUND_CONST) ^ t ^ rotr(t, 1)
                    ^ N'(z0_bit(6'(round_i)));
    end

endmodule

// File: rtl/simon_control_inl.sv
// SIMON32/64 encryptor, one round per clock, key schedule expanded on the fly.
// Handshake: newData starts an encryption from IDLE, doneData holds the result
// in DONE until readData acknowledges it.
// Build option: define SIMON_CIPHER_MASK_EN to force cipher to zero whenever
// doneData is low; otherwise cipher exposes the state register at all times.
module simon_control_inl
    import simon_pkg::*;
#(
    parameter int unsigned N = N_DEF,
    parameter int unsigned M = M_DEF,
    parameter int unsigned T = T_DEF,
    parameter int unsigned C = C_DEF
) (
    input  logic                clk,
    input  logic                nR,
    input  logic                newData,
    input  logic                readData,
    input  logic [2*N-1:0]      plain,
    input  logic [M-1:0][N-1:0] key,
    output logic                doneData,
    output logic                doneKey,
    output logic [2*N-1:0]      cipher
);

    localparam logic [C-1:0] LAST_ROUND = C'(T - 1);

    state_e              state_q, state_d;
    logic [C-1:0]        cnt_q, cnt_d;
    logic [N-1:0]        x_q, x_d;
    logic [N-1:0]        y_q, y_d;
    logic [M-1:0][N-1:0] key_q, key_d;
    logic                done_q, done_d;
    logic                dkey_q, dkey_d;

    logic [N-1:0]        x_round;
    logic [N-1:0]        key_new;
    logic                ack;

    // Acknowledge only counts once the result is actually being presented
    assign ack = (state_q == ST_DONE) && done_q && readData;

    simon_round #(
        .N (N),
        .C (C)
    ) u_round (
        .x_i         (x_q),
        .y_i         (y_q),
        .k0_i        (key_q[0]),
        .k1_i        (key_q[1]),
        .k_last_i    (key_q[M-1]),
        .round_i     (cnt_q),
        .x_next_c_o  (x_round),
        .key_new_c_o (key_new)
    );

    // State register
    always_ff @(posedge clk) begin
        if (nR) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (newData)              state_d = ST_RUN;
            ST_RUN:  if (cnt_q == LAST_ROUND)  state_d = ST_DONE;
            ST_DONE: if (ack)                  state_d = ST_IDLE;
            default:                           state_d = ST_IDLE;
        endcase
    end

    // Datapath and output next values
    always_comb begin
        cnt_d  = cnt_q;
        x_d    = x_q;
        y_d    = y_q;
        key_d  = key_q;
        done_d = 1'b0;
        dkey_d = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (newData) begin
                    x_d    = plain[2*N-1:N];
                    y_d    = plain[N-1:0];
                    key_d  = key;
                    cnt_d  = '0;
                    dkey_d = 1'b1;
                end
            end
            ST_RUN: begin
                x_d   = x_round;
                y_d   = x_q;
                key_d = {key_new, key_q[M-1:1]};
                cnt_d = cnt_q + C'(1);
            end
            ST_DONE: begin
                done_d = !ack;
            end
            default: begin
                done_d = 1'b0;
            end
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge clk) begin
        if (nR) begin
            cnt_q  <= '0;
            x_q    <= '0;
            y_q    <= '0;
            key_q  <= '0;
            done_q <= 1'b0;
            dkey_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            x_q    <= x_d;
            y_q    <= y_d;
            key_q  <= key_d;
            done_q <= done_d;
            dkey_q <= dkey_d;
        end
    end

    assign doneData = done_q;
    assign doneKey  = dkey_q;

`ifdef SIMON_CIPHER_MASK_EN
    assign cipher = done_q ? {x_q, y_q} : '0;
`else
    assign cipher = {x_q, y_q};
`endif

endmodule

// File: tb/tb_simon_control_inl.sv
// Scoreboard bench for simon_control_inl using the SIMON32/64 reference vector.
module tb_simon_control_inl;

    localparam logic [31:0] PT      = 32'h65656877;
    localparam logic [63:0] KEY     = {16'h1918, 16'h1110, 16'h0908, 16'h0100};
    localparam logic [31:0] CT      = 32'hc69be9bb;
    localparam int unsigned LAT     = 33;
`ifdef SIMON_CIPHER_MASK_EN
    localparam logic [31:0] ROUND1  = 32'h0;
`else
    localparam logic [31:0] ROUND1  = 32'hbca26565;
`endif

    typedef struct {
        logic [31:0] c;
        int unsigned cyc;
    } exp_t;

    logic              clk = 1'b0;
    logic              nR;
    logic              newData;
    logic              readData;
    logic [31:0]       plain;
    logic [3:0][15:0]  key;
    logic              doneData;
    logic              doneKey;
    logic [31:0]       cipher;

    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned cyc    = 0;
    exp_t        q_res[$];
    int unsigned q_key[$];
    logic        done_prev = 1'b0;

    simon_control_inl dut (
        .clk      (clk),
        .nR       (nR),
        .newData  (newData),
        .readData (readData),
        .plain    (plain),
        .key      (key),
        .doneData (doneData),
        .doneKey  (doneKey),
        .cipher   (cipher)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step(input int unsigned n);
        repeat (n) @(negedge clk);
    endtask

    // Issue a request held for two cycles; returns one cycle after capture
    task automatic start_run(input logic [31:0] p, input logic [31:0] exp_c);
        exp_t e;
        plain   = p;
        key     = KEY;
        newData = 1'b1;
        e.c     = exp_c;
        e.cyc   = cyc + 1 + LAT;
        q_res.push_back(e);
        q_key.push_back(cyc + 1);
        step(2);
        newData = 1'b0;
    endtask

    task automatic wait_done(input int unsigned bound);
        int unsigned n = 0;
        while (!doneData && n < bound) begin
            @(negedge clk);
            n++;
        end
        check("done_timeout", 64'(doneData), 64'(1));
    endtask

    task automatic ack_result();
        readData = 1'b1;
        step(1);
        readData = 1'b0;
        check("ack_clears_done", 64'(doneData), 64'(0));
    endtask

    // Monitor: compares each presented result and key strobe against the scoreboard
    always @(negedge clk) begin
        exp_t        e;
        int unsigned k;
        if (doneData && !done_prev) begin
            check("result_pending", 64'(q_res.size() > 0), 64'(1));
            if (q_res.size() > 0) begin
                e = q_res.pop_front();
                check("cipher", 64'(cipher), 64'(e.c));
                check("latency_cycle", 64'(cyc), 64'(e.cyc));
            end
        end
        if (doneKey) begin
            check("key_pending", 64'(q_key.size() > 0), 64'(1));
            if (q_key.size() > 0) begin
                k = q_key.pop_front();
                check("doneKey_cycle", 64'(cyc), 64'(k));
            end
        end
        done_prev = doneData;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        exp_t dropped;
        nR       = 1'b1;
        newData  = 1'b0;
        readData = 1'b0;
        plain    = '0;
        key      = '0;

        // Reset state
        step(2);
        check("rst_doneData", 64'(doneData), 64'(0));
        check("rst_doneKey",  64'(doneKey),  64'(0));
        check("rst_cipher",   64'(cipher),   64'(0));
        nR = 1'b0;
        step(1);

        // Reference vector, first round visible on cipher
        start_run(PT, CT);
        check("round1_cipher", 64'(cipher), 64'(ROUND1));
        wait_done(60);

        // Result held while unacknowledged
        for (int i = 0; i < 10; i++) begin
            step(1);
            check("hold_done",   64'(doneData), 64'(1));
            check("hold_cipher", 64'(cipher),   64'(CT));
        end

        // Two-cycle acknowledge, then repeat with the same inputs
        readData = 1'b1;
        step(2);
        readData = 1'b0;
        check("ack2_clears_done", 64'(doneData), 64'(0));
        start_run(PT, CT);
        wait_done(60);
        ack_result();

        // Inputs change, newData and readData pulse during RUN: all ignored
        start_run(PT, CT);
        step(3);
        plain    = '0;
        key      = '0;
        newData  = 1'b1;
        readData = 1'b1;
        step(2);
        newData  = 1'b0;
        readData = 1'b0;
        wait_done(60);
        // newData in DONE ignored
        newData = 1'b1;
        step(2);
        newData = 1'b0;
        check("done_ignores_new", 64'(doneData), 64'(1));
        check("done_cipher_kept", 64'(cipher),   64'(CT));
        ack_result();

        // newData held across the acknowledge restarts on the following edge
        start_run(PT, CT);
        wait_done(60);
        readData = 1'b1;
        newData  = 1'b1;
        begin
            exp_t e;
            e.c   = CT;
            e.cyc = cyc + 2 + LAT;
            q_res.push_back(e);
            q_key.push_back(cyc + 2);
        end
        step(1);
        readData = 1'b0;
        check("back_to_back_ack", 64'(doneData), 64'(0));
        step(1);
        newData = 1'b0;
        wait_done(60);
        ack_result();

        // Reset mid-RUN aborts; reset overrides newData/readData
        start_run(PT, CT);
        step(8);
        nR       = 1'b1;
        newData  = 1'b1;
        readData = 1'b1;
        dropped  = q_res.pop_front();
        step(1);
        nR       = 1'b0;
        newData  = 1'b0;
        readData = 1'b0;
        check("abort_doneData", 64'(doneData), 64'(0));
        check("abort_doneKey",  64'(doneKey),  64'(0));
        check("abort_cipher",   64'(cipher),   64'(0));
        step(45);
        check("abort_no_result", 64'(doneData), 64'(0));
        start_run(PT, CT);
        wait_done(60);
        ack_result();

        step(2);
        check("results_drained", 64'(q_res.size()), 64'(0));
        check("keys_drained",    64'(q_key.size()), 64'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
